// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the EXU writeback arbiter: unit encoding, result record
// and the default datapath width.
package exu_wb_arb_pkg;

   localparam int WB_XLEN = 32;

   typedef enum logic [1:0] {
      UNIT_ALU = 2'd0,
      UNIT_MUL = 2'd1,
      UNIT_DIV = 2'd2,
      UNIT_LSU = 2'd3
   } wb_unit_e;

   typedef struct packed {
      logic               valid;
      logic [4:0]         rd_addr;
      logic [WB_XLEN-1:0] data;
   } wb_result_t;

   // Only multi-cycle units are tracked by counters and the scoreboard.
   function automatic logic unit_tracked(wb_unit_e unit);
      return unit != UNIT_ALU;
   endfunction

endpackage

// File: rtl/exu_wb_arb_if.sv
// Issue, result, writeback, status and scoreboard signals between IDU1,
// the execution units and the writeback arbiter.
interface exu_wb_arb_if
   import exu_wb_arb_pkg::*;
#(
   parameter int XLEN = WB_XLEN
) ();

   logic            iss_valid;
   wb_unit_e        iss_unit;
   logic            iss_rd_wr;
   logic [4:0]      iss_rd_addr;

   logic            alu_res_valid;
   logic            alu_res_wr;
   logic [4:0]      alu_res_rd_addr;
   logic [XLEN-1:0] alu_res_data;

   logic            mul_res_valid;
   logic [4:0]      mul_res_rd_addr;
   logic [XLEN-1:0] mul_res_data;
   logic            mul_res_ack;

   logic            div_res_valid;
   logic [4:0]      div_res_rd_addr;
   logic [XLEN-1:0] div_res_data;
   logic            div_res_ack;

   logic            lsu_res_valid;
   logic [4:0]      lsu_res_rd_addr;
   logic [XLEN-1:0] lsu_res_data;
   logic            lsu_res_ack;

   logic            exu_wb_rd_wr_en;
   logic [4:0]      exu_wb_rd_addr;
   logic [XLEN-1:0] exu_wb_data;

   logic            exu_mul_busy;
   logic            exu_div_busy;
   logic            exu_lsu_busy;
   logic            exu_wb_stall;

   logic [4:0]      sb_rs1_addr;
   logic [4:0]      sb_rs2_addr;
   logic            sb_rs1_pending;
   logic            sb_rs2_pending;

   modport master (
      output iss_valid, iss_unit, iss_rd_wr, iss_rd_addr,
      output alu_res_valid, alu_res_wr, alu_res_rd_addr, alu_res_data,
      output mul_res_valid, mul_res_rd_addr, mul_res_data,
      output div_res_valid, div_res_rd_addr, div_res_data,
      output lsu_res_valid, lsu_res_rd_addr, lsu_res_data,
      output sb_rs1_addr, sb_rs2_addr,
      input  mul_res_ack, div_res_ack, lsu_res_ack,
      input  exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data,
      input  exu_mul_busy, exu_div_busy, exu_lsu_busy, exu_wb_stall,
      input  sb_rs1_pending, sb_rs2_pending
   );

   modport slave (
      input  iss_valid, iss_unit, iss_rd_wr, iss_rd_addr,
      input  alu_res_valid, alu_res_wr, alu_res_rd_addr, alu_res_data,
      input  mul_res_valid, mul_res_rd_addr, mul_res_data,
      input  div_res_valid, div_res_rd_addr, div_res_data,
      input  lsu_res_valid, lsu_res_rd_addr, lsu_res_data,
      input  sb_rs1_addr, sb_rs2_addr,
      output mul_res_ack, div_res_ack, lsu_res_ack,
      output exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data,
      output exu_mul_busy, exu_div_busy, exu_lsu_busy, exu_wb_stall,
      output sb_rs1_pending, sb_rs2_pending
   );

endinterface

// File: rtl/exu_wb_arb_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, x0 is
// never pending. Set has priority over a same-cycle clear of the same register.
module exu_wb_arb_scoreboard (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_en,
   input  logic [4:0] set_addr,
   input  logic       clr_en,
   input  logic [4:0] clr_addr,
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   output logic       rs1_pending,
   output logic       rs2_pending
);

   logic [31:1] pend;
   logic [31:0] pend_all;

   assign pend_all = {pend, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (set_en && set_addr == 5'(i)) begin
               pend[i] <= 1'b1;
            end else if (clr_en && clr_addr == 5'(i)) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   assign rs1_pending = pend_all[rs1_addr];
   assign rs2_pending = pend_all[rs2_addr];

endmodule

// File: rtl/exu_wb_arb.sv
// EXU writeback arbiter: tracks in-flight MUL/DIV/LSU ops, picks one result per
// cycle for the register-file write port and raises a stall on starvation.
module exu_wb_arb
   import exu_wb_arb_pkg::*;
#(
   parameter int XLEN          = WB_XLEN,
   parameter int MUL_MAX_OUTST = 2,
   parameter int LSU_MAX_OUTST = 1,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   exu_wb_arb_if.slave bus
);

   localparam int MUL_CW = $clog2(MUL_MAX_OUTST + 1);
   localparam int LSU_CW = $clog2(LSU_MAX_OUTST + 1);
   localparam int STV_CW = $clog2(STARVE_LIMIT + 1);

   logic              gnt_alu, gnt_lsu, gnt_mul, gnt_div, gnt_trk;
   logic              trk_valid;
   logic              iss_mul, iss_div, iss_lsu, sb_set;
   logic              win_valid, win_wr;
   logic [4:0]        win_rd;
   logic [XLEN-1:0]   win_data;
   logic [MUL_CW-1:0] mul_cnt, mul_cnt_nxt;
   logic [LSU_CW-1:0] lsu_cnt, lsu_cnt_nxt;
   logic              div_cnt, div_cnt_nxt;
   logic [STV_CW-1:0] stv_cnt, stv_cnt_nxt;

   // Fixed priority ALU > LSU > MUL > DIV; nothing is granted while in reset.
   always_comb begin
      gnt_alu = !rst && bus.alu_res_valid;
      gnt_lsu = !rst && !bus.alu_res_valid && bus.lsu_res_valid;
      gnt_mul = !rst && !bus.alu_res_valid && !bus.lsu_res_valid && bus.mul_res_valid;
      gnt_div = !rst && !bus.alu_res_valid && !bus.lsu_res_valid && !bus.mul_res_valid
                && bus.div_res_valid;
      gnt_trk   = gnt_lsu || gnt_mul || gnt_div;
      trk_valid = bus.lsu_res_valid || bus.mul_res_valid || bus.div_res_valid;
   end

   assign bus.lsu_res_ack = gnt_lsu;
   assign bus.mul_res_ack = gnt_mul;
   assign bus.div_res_ack = gnt_div;

   always_comb begin
      win_valid = 1'b0;
      win_wr    = 1'b0;
      win_rd    = '0;
      win_data  = '0;
      if (gnt_alu) begin
         win_valid = 1'b1;
         win_wr    = bus.alu_res_wr;
         win_rd    = bus.alu_res_rd_addr;
         win_data  = bus.alu_res_data;
      end else if (gnt_lsu) begin
         win_valid = 1'b1;
         win_wr    = 1'b1;
         win_rd    = bus.lsu_res_rd_addr;
         win_data  = bus.lsu_res_data;
      end else if (gnt_mul) begin
         win_valid = 1'b1;
         win_wr    = 1'b1;
         win_rd    = bus.mul_res_rd_addr;
         win_data  = bus.mul_res_data;
      end else if (gnt_div) begin
         win_valid = 1'b1;
         win_wr    = 1'b1;
         win_rd    = bus.div_res_rd_addr;
         win_data  = bus.div_res_data;
      end
   end

   always_comb begin
      iss_mul = bus.iss_valid && bus.iss_unit == UNIT_MUL;
      iss_div = bus.iss_valid && bus.iss_unit == UNIT_DIV;
      iss_lsu = bus.iss_valid && bus.iss_unit == UNIT_LSU;
      sb_set  = bus.iss_valid && bus.iss_rd_wr && unit_tracked(bus.iss_unit)
                && bus.iss_rd_addr != 5'd0;
   end

   always_comb begin
      mul_cnt_nxt = mul_cnt;
      if (iss_mul && !gnt_mul)      mul_cnt_nxt = mul_cnt + MUL_CW'(1);
      else if (!iss_mul && gnt_mul) mul_cnt_nxt = mul_cnt - MUL_CW'(1);

      lsu_cnt_nxt = lsu_cnt;
      if (iss_lsu && !gnt_lsu)      lsu_cnt_nxt = lsu_cnt + LSU_CW'(1);
      else if (!iss_lsu && gnt_lsu) lsu_cnt_nxt = lsu_cnt - LSU_CW'(1);

      div_cnt_nxt = div_cnt;
      if (iss_div && !gnt_div)      div_cnt_nxt = 1'b1;
      else if (!iss_div && gnt_div) div_cnt_nxt = 1'b0;

      // Saturates at the limit so the stall holds until a tracked unit wins.
      stv_cnt_nxt = stv_cnt;
      if (gnt_trk)                                        stv_cnt_nxt = '0;
      else if (trk_valid && stv_cnt != STV_CW'(STARVE_LIMIT)) stv_cnt_nxt = stv_cnt + STV_CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_cnt             <= '0;
         lsu_cnt             <= '0;
         div_cnt             <= 1'b0;
         stv_cnt             <= '0;
         bus.exu_mul_busy    <= 1'b0;
         bus.exu_div_busy    <= 1'b0;
         bus.exu_lsu_busy    <= 1'b0;
         bus.exu_wb_stall    <= 1'b0;
         bus.exu_wb_rd_wr_en <= 1'b0;
         bus.exu_wb_rd_addr  <= '0;
         bus.exu_wb_data     <= '0;
      end else begin
         mul_cnt          <= mul_cnt_nxt;
         lsu_cnt          <= lsu_cnt_nxt;
         div_cnt          <= div_cnt_nxt;
         stv_cnt          <= stv_cnt_nxt;
         bus.exu_mul_busy <= (mul_cnt_nxt != '0);
         bus.exu_lsu_busy <= (lsu_cnt_nxt != '0);
         bus.exu_div_busy <= div_cnt_nxt;
         bus.exu_wb_stall <= (stv_cnt_nxt == STV_CW'(STARVE_LIMIT));
         if (win_valid) begin
            bus.exu_wb_rd_wr_en <= win_wr && (win_rd != 5'd0);
            bus.exu_wb_rd_addr  <= win_rd;
            bus.exu_wb_data     <= win_data;
         end else begin
            bus.exu_wb_rd_wr_en <= 1'b0;
         end
      end
   end

   exu_wb_arb_scoreboard u_sb (
      .clk         (clk),
      .rst         (rst),
      .set_en      (sb_set),
      .set_addr    (bus.iss_rd_addr),
      .clr_en      (gnt_trk),
      .clr_addr    (win_rd),
      .rs1_addr    (bus.sb_rs1_addr),
      .rs2_addr    (bus.sb_rs2_addr),
      .rs1_pending (bus.sb_rs1_pending),
      .rs2_pending (bus.sb_rs2_pending)
   );

   // Issuing into a full unit or acking an empty one is an upstream bug.
   a_mul_over:  assert property (@(posedge clk) disable iff (rst)
                   !(iss_mul && !gnt_mul && mul_cnt == MUL_CW'(MUL_MAX_OUTST)));
   a_lsu_over:  assert property (@(posedge clk) disable iff (rst)
                   !(iss_lsu && !gnt_lsu && lsu_cnt == LSU_CW'(LSU_MAX_OUTST)));
   a_div_over:  assert property (@(posedge clk) disable iff (rst)
                   !(iss_div && !gnt_div && div_cnt));
   a_mul_under: assert property (@(posedge clk) disable iff (rst) !(gnt_mul && mul_cnt == '0));
   a_lsu_under: assert property (@(posedge clk) disable iff (rst) !(gnt_lsu && lsu_cnt == '0));
   a_div_under: assert property (@(posedge clk) disable iff (rst) !(gnt_div && !div_cnt));

endmodule
